fifo_wr_arbiter: RTL

Write-side arbiter sharing the single write port of the team's asynchronous FIFO among NUM_REQ requesters in the write clock domain. Grants are round-robin and burst-based: one requester owns the port until its packet ends, its burst limit is reached, or it drops its request. Backpressure comes from the FIFO's full and almost-full flags. The block also checks the FIFO's write acknowledge and overflow flags for protocol errors.

---
 rtl/fifo_wr_arbiter_if.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the async FIFO write port.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        last_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      fifo_wr_en_o;
  logic [DATA_W-1:0]         fifo_wdata_o;
  logic                      fifo_full_i;
  logic                      fifo_almost_full_i;
  logic                      fifo_wr_ack_i;
  logic                      fifo_overflow_i;
  logic [OW-1:0]             owner_o;
  logic                      busy_o;
  logic                      err_o;

  modport slave (
    input  req_i, data_i, last_i,
    input  fifo_full_i, fifo_almost_full_i, fifo_wr_ack_i, fifo_overflow_i,
    output gnt_o, fifo_wr_en_o, fifo_wdata_o, owner_o, busy_o, err_o
  );

  modport master (
    output req_i, data_i, last_i,
    output fifo_full_i, fifo_almost_full_i, fifo_wr_ack_i, fifo_overflow_i,
    input  gnt_o, fifo_wr_en_o, fifo_wdata_o, owner_o, busy_o, err_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port; one bubble cycle per grant, then 1 beat/cycle.
// fifo_full stalls the owner in place (grant combinational, same cycle); almost-full gates new bursts.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter bit AF_GATE   = 1'b1
) (
  input  logic              wr_clk_i,
  input  logic              a_rst_i,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [OW-1:0]      owner, owner_nxt, winner, idx;
  logic [CW-1:0]      beat_cnt, beat_cnt_nxt;
  logic               ptr_vld, ptr_vld_nxt;
  logic               found;
  int                 start_idx;
  logic               accept;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0]  wdata;
  logic               exp_ack;
  logic               err;

  // Until the first grant after reset the search starts at 0 rather than owner+1.
  always_comb begin
    winner    = '0;
    idx       = '0;
    found     = 1'b0;
    start_idx = ptr_vld ? ((int'(owner) + 1) % NUM_REQ) : 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = OW'((start_idx + i) % NUM_REQ);
      if (!found && bus.req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    ptr_vld_nxt  = ptr_vld;
    accept       = 1'b0;
    gnt          = '0;
    wdata        = '0;
    case (state)
      IDLE: begin
        if (found && !(AF_GATE && bus.fifo_almost_full_i)) begin
          state_nxt    = BURST;
          owner_nxt    = winner;
          beat_cnt_nxt = '0;
          ptr_vld_nxt  = 1'b1;
        end
      end
      BURST: begin
        wdata      = bus.data_i[owner*DATA_W +: DATA_W];
        accept     = bus.req_i[owner] && !bus.fifo_full_i;
        gnt[owner] = accept;
        // A full FIFO freezes everything, including an abandon by the owner.
        if (!bus.fifo_full_i) begin
          if (!bus.req_i[owner]) begin
            state_nxt = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CW'(1);
            if (bus.last_i[owner] || beat_cnt_nxt == CW'(MAX_BURST))
              state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      ptr_vld  <= 1'b0;
      exp_ack  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
      ptr_vld  <= ptr_vld_nxt;
      exp_ack  <= accept;
      err      <= err | (bus.fifo_wr_ack_i != exp_ack) | bus.fifo_overflow_i;
    end
  end

  assign bus.gnt_o        = gnt;
  assign bus.fifo_wr_en_o = accept;
  assign bus.fifo_wdata_o = wdata;
  assign bus.owner_o      = owner;
  assign bus.busy_o       = (state == BURST);
  assign bus.err_o        = err;
endmodule
